tri_coverage: RTL and testbench

TRI_COVERAGE -- requirements
Module: tri_coverage

---
 rtl/tri_pkg.sv | 22 ++
 rtl/tri_edge_eval.sv | 66 ++++++
 rtl/tri_coverage.sv | 178 +++++++++++++++++
 tb/tb_tri_coverage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared definitions for the triangle coverage block: FSM states and edge sizing.
package tri_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP1 = 3'd1,
    ST_SETUP2 = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } tri_state_e;

  localparam int COORD_WIDTH_DEF = 16;
  localparam int EDGE_WIDTH      = 2*COORD_WIDTH_DEF+3;
  localparam int NUM_EDGES       = 3;
  localparam int PIPE_STAGES     = 3;

  // Width that holds dx*(py-vy) - dy*(px-vx) for any unsigned coordinate.
  function automatic int edge_width(input int cw);
    return 2*cw+3;
  endfunction

endpackage

// File: rtl/tri_edge_eval.sv
// One edge function evaluation, 3 stages (subtract, multiply, sum/compare).
// TRI_TOP_LEFT_RULE_EN: when defined, E == 0 is inside only for a top-left edge.
module tri_edge_eval
  import tri_pkg::*;
#(
  parameter int CW = 16,
  parameter int EW = 2*CW+3
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          en_in,
  input  logic [CW-1:0] px_in,
  input  logic [CW-1:0] py_in,
  input  logic [CW-1:0] vx_in,
  input  logic [CW-1:0] vy_in,
  input  logic [CW:0]   dx_in,
  input  logic [CW:0]   dy_in,
  input  logic          neg_in,
`ifdef TRI_TOP_LEFT_RULE_EN
  input  logic          tl_in,
`endif
  output logic          inside_out
);

  logic [CW:0]          tx_q, tx_d, ty_q, ty_d;
  logic signed [EW-1:0] m1_q, m1_d, m2_q, m2_d;
  logic signed [EW-1:0] e_raw, e_nrm;
  logic                 inside_q, inside_d;
  logic                 on_edge_ok;

`ifdef TRI_TOP_LEFT_RULE_EN
  assign on_edge_ok = tl_in;
`else
  assign on_edge_ok = 1'b1;
`endif

  always_comb begin
    tx_d  = {1'b0, px_in} - {1'b0, vx_in};
    ty_d  = {1'b0, py_in} - {1'b0, vy_in};
    m1_d  = EW'($signed(dx_in)) * EW'($signed(ty_q));
    m2_d  = EW'($signed(dy_in)) * EW'($signed(tx_q));
    e_raw = m1_q - m2_q;
    // Flip by winding so both orientations test "inside" as positive.
    e_nrm = neg_in ? -e_raw : e_raw;
    inside_d = (!e_nrm[EW-1] && (e_nrm != '0)) || ((e_nrm == '0) && on_edge_ok);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_q     <= '0;
      ty_q     <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      inside_q <= 1'b0;
    end else if (en_in) begin
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      inside_q <= inside_d;
    end
  end

  assign inside_out = inside_q;

endmodule

// File: rtl/tri_coverage.sv
// Triangle point-coverage engine: two setup cycles per triangle, then a 3-stage point pipeline.
// TRI_TOP_LEFT_RULE_EN: when defined, points on an edge count only for top-left edges.
module tri_coverage
  import tri_pkg::*;
#(
  parameter int COORD_WIDTH = 16,
  parameter int NUM_LANES   = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             tri_valid_in,
  output logic                             tri_ready_out,
  input  logic [3*COORD_WIDTH-1:0]         tri_x_in,
  input  logic [3*COORD_WIDTH-1:0]         tri_y_in,
  input  logic                             pt_valid_in,
  output logic                             pt_ready_out,
  input  logic [NUM_LANES*COORD_WIDTH-1:0] pt_x_in,
  input  logic [NUM_LANES*COORD_WIDTH-1:0] pt_y_in,
  input  logic                             pt_last_in,
  output logic                             cov_valid_out,
  input  logic                             cov_ready_in,
  output logic [NUM_LANES-1:0]             cov_mask_out,
  output logic                             cov_last_out,
  output logic                             tri_degenerate_out,
  output logic                             busy_out
);

  localparam int CW = COORD_WIDTH;
  localparam int DW = CW+1;
  localparam int EW = edge_width(CW);

  tri_state_e                     state_q, state_d;
  logic                           init_q;
  logic [NUM_EDGES-1:0][CW-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [NUM_EDGES-1:0][DW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic signed [EW-1:0]           area_q, area_d;
  logic                           deg_q, deg_d;
  logic [PIPE_STAGES:1]           vld_pipe_q, vld_pipe_d;
  logic [PIPE_STAGES:1]           last_pipe_q, last_pipe_d;
  logic                           adv, tri_acc, pt_acc, area_neg, area_zero;
  logic [NUM_LANES-1:0][NUM_EDGES-1:0] inside_w;

`ifdef TRI_TOP_LEFT_RULE_EN
  logic [NUM_EDGES-1:0]           tl_q, tl_d;
  logic [DW-1:0]                  dxn, dyn;
`endif

  assign adv           = !cov_valid_out || cov_ready_in;
  assign tri_ready_out = (state_q == ST_IDLE) && init_q;
  assign pt_ready_out  = (state_q == ST_RUN) && adv;
  assign tri_acc       = tri_valid_in && tri_ready_out;
  assign pt_acc        = pt_valid_in && pt_ready_out;
  assign area_neg      = area_q[EW-1];
  assign area_zero     = (area_q == '0);
  assign busy_out      = (state_q != ST_IDLE);
  assign cov_valid_out = vld_pipe_q[PIPE_STAGES];
  assign cov_last_out  = last_pipe_q[PIPE_STAGES];
  assign tri_degenerate_out = deg_q;

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    area_d  = area_q;
    deg_d   = 1'b0;
`ifdef TRI_TOP_LEFT_RULE_EN
    tl_d    = tl_q;
    dxn     = '0;
    dyn     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tri_acc) begin
          for (int i = 0; i < NUM_EDGES; i++) begin
            vx_d[i] = tri_x_in[i*CW +: CW];
            vy_d[i] = tri_y_in[i*CW +: CW];
          end
          state_d = ST_SETUP1;
        end
      end
      ST_SETUP1: begin
        for (int i = 0; i < NUM_EDGES; i++) begin
          dx_d[i] = {1'b0, vx_q[(i+1)%NUM_EDGES]} - {1'b0, vx_q[i]};
          dy_d[i] = {1'b0, vy_q[(i+1)%NUM_EDGES]} - {1'b0, vy_q[i]};
        end
        state_d = ST_SETUP2;
      end
      ST_SETUP2: begin
        // C-A is the negated third edge, so dx0*dy2' - dy0*dx2' = dy0*dx2 - dx0*dy2.
        area_d = EW'($signed(dy_q[0])) * EW'($signed(dx_q[2]))
               - EW'($signed(dx_q[0])) * EW'($signed(dy_q[2]));
        deg_d  = (area_d == '0);
`ifdef TRI_TOP_LEFT_RULE_EN
        for (int i = 0; i < NUM_EDGES; i++) begin
          dxn = area_d[EW-1] ? -dx_q[i] : dx_q[i];
          dyn = area_d[EW-1] ? -dy_q[i] : dy_q[i];
          tl_d[i] = dyn[DW-1] || ((dyn == '0) && !dxn[DW-1] && (dxn != '0));
        end
`endif
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pt_acc && pt_last_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cov_valid_out && cov_ready_in && cov_last_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    if (adv) begin
      vld_pipe_d  = {vld_pipe_q[PIPE_STAGES-1:1], pt_acc};
      last_pipe_d = {last_pipe_q[PIPE_STAGES-1:1], pt_acc && pt_last_in};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      init_q      <= 1'b0;
      vx_q        <= '0;
      vy_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      area_q      <= '0;
      deg_q       <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
`ifdef TRI_TOP_LEFT_RULE_EN
      tl_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      area_q      <= area_d;
      deg_q       <= deg_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
`ifdef TRI_TOP_LEFT_RULE_EN
      tl_q        <= tl_d;
`endif
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
      tri_edge_eval #(.CW(CW), .EW(EW)) u_eval (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en_in      (adv),
        .px_in      (pt_x_in[l*CW +: CW]),
        .py_in      (pt_y_in[l*CW +: CW]),
        .vx_in      (vx_q[e]),
        .vy_in      (vy_q[e]),
        .dx_in      (dx_q[e]),
        .dy_in      (dy_q[e]),
        .neg_in     (area_neg),
`ifdef TRI_TOP_LEFT_RULE_EN
        .tl_in      (tl_q[e]),
`endif
        .inside_out (inside_w[l][e])
      );
    end
    // A zero-area triangle covers nothing, whatever the edge tests say.
    assign cov_mask_out[l] = (&inside_w[l]) && !area_zero;
  end

endmodule

// File: tb/tb_tri_coverage.sv
// Directed bench for tri_coverage: hand-computed masks, latency, backpressure and reset.
module tb_tri_coverage;
  localparam int CW = 16;
  localparam int NL = 4;
  localparam logic [6*NL-1:0] MSEQ = {4'h5, 4'hA, 4'h8, 4'h4, 4'h2, 4'h1};

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic           tri_valid_in = 1'b0;
  logic           tri_ready_out;
  logic [3*CW-1:0] tri_x_in = '0, tri_y_in = '0;
  logic           pt_valid_in = 1'b0;
  logic           pt_ready_out;
  logic [NL*CW-1:0] pt_x_in = '0, pt_y_in = '0;
  logic           pt_last_in = 1'b0;
  logic           cov_valid_out;
  logic           cov_ready_in = 1'b1;
  logic [NL-1:0]  cov_mask_out;
  logic           cov_last_out;
  logic           tri_degenerate_out;
  logic           busy_out;

  always #5 clk_in = ~clk_in;

  tri_coverage #(.COORD_WIDTH(CW), .NUM_LANES(NL)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
    .tri_x_in(tri_x_in), .tri_y_in(tri_y_in),
    .pt_valid_in(pt_valid_in), .pt_ready_out(pt_ready_out),
    .pt_x_in(pt_x_in), .pt_y_in(pt_y_in), .pt_last_in(pt_last_in),
    .cov_valid_out(cov_valid_out), .cov_ready_in(cov_ready_in),
    .cov_mask_out(cov_mask_out), .cov_last_out(cov_last_out),
    .tri_degenerate_out(tri_degenerate_out), .busy_out(busy_out)
  );

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int deg_cnt = 0;
  logic [NL-1:0] res_mask[$];
  logic          res_last[$];
  int            res_cyc[$];
  int            acc_cyc[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (cov_valid_out && cov_ready_in) begin
        res_mask.push_back(cov_mask_out);
        res_last.push_back(cov_last_out);
        res_cyc.push_back(cyc);
      end
      if (pt_valid_in && pt_ready_out) acc_cyc.push_back(cyc);
      if (tri_degenerate_out) deg_cnt = deg_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL*CW-1:0] by_mask(input logic [NL-1:0] m);
    logic [NL*CW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*CW +: CW] = m[i] ? CW'(1) : CW'(9);
    return v;
  endfunction

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
    int n;
    n = 0;
    tri_valid_in = 1'b1;
    tri_x_in = {CW'(cx), CW'(bx), CW'(ax)};
    tri_y_in = {CW'(cy), CW'(by), CW'(ay)};
    @(negedge clk_in);
    while (!tri_ready_out && n < 200) begin n++; @(negedge clk_in); end
    if (n >= 200) chk("tri_ready_timeout", 32'd0, 32'd1);
    @(posedge clk_in); #1;
    tri_valid_in = 1'b0;
  endtask

  task automatic beat(input logic [NL*CW-1:0] x, input logic [NL*CW-1:0] y, input logic last);
    int n;
    n = 0;
    pt_valid_in = 1'b1; pt_x_in = x; pt_y_in = y; pt_last_in = last;
    @(negedge clk_in);
    while (!pt_ready_out && n < 200) begin n++; @(negedge clk_in); end
    if (n >= 200) chk("pt_ready_timeout", 32'd0, 32'd1);
    @(posedge clk_in); #1;
    pt_valid_in = 1'b0; pt_last_in = 1'b0;
  endtask

  task automatic wait_res(input int want, input string tag);
    int n;
    n = 0;
    while (res_mask.size() < want && n < 500) begin @(posedge clk_in); #1; n++; end
    chk(tag, res_mask.size(), want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, abase, dbase;
    logic [6*NL-1:0] mseq;
    logic [NL-1:0] mhold;
    mseq = MSEQ;

    #23;
    chk("rst_tri_ready", tri_ready_out, 0);
    chk("rst_pt_ready", pt_ready_out, 0);
    chk("rst_cov_valid", cov_valid_out, 0);
    chk("rst_mask", cov_mask_out, 0);
    chk("rst_last", cov_last_out, 0);
    chk("rst_degen", tri_degenerate_out, 0);
    chk("rst_busy", busy_out, 0);
    @(negedge clk_in); rst_n_in = 1'b1; #1;
    chk("tri_ready_before_edge", tri_ready_out, 0);
    @(posedge clk_in); #1;
    chk("tri_ready_first_edge", tri_ready_out, 1);

    // Counter-clockwise right triangle, mixed inside/outside/on-edge lanes.
    base = res_mask.size(); abase = acc_cyc.size(); dbase = deg_cnt;
    send_tri(0, 0, 10, 0, 0, 10);
    chk("busy_after_tri", busy_out, 1);
    beat({16'd0, 16'd5, 16'd9, 16'd1}, {16'd0, 16'd5, 16'd9, 16'd1}, 1'b1);
    wait_res(base + 1, "ccw_count");
    chk("ccw_mask", res_mask[base], 4'b1101);
    chk("ccw_last", res_last[base], 1);
    chk("ccw_latency", res_cyc[base] - acc_cyc[abase], 3);
    chk("ccw_no_degen", deg_cnt - dbase, 0);

    // Same triangle, opposite winding.
    base = res_mask.size();
    send_tri(0, 0, 0, 10, 10, 0);
    beat({16'd0, 16'd5, 16'd9, 16'd1}, {16'd0, 16'd5, 16'd9, 16'd1}, 1'b1);
    wait_res(base + 1, "cw_count");
    chk("cw_mask", res_mask[base], 4'b1101);

    // Collinear vertices: one pulse, nothing covered.
    base = res_mask.size(); dbase = deg_cnt;
    send_tri(0, 0, 5, 5, 10, 10);
    beat({16'd0, 16'd2, 16'd1, 16'd5}, {16'd0, 16'd2, 16'd1, 16'd5}, 1'b0);
    beat({16'd3, 16'd7, 16'd1, 16'd10}, {16'd3, 16'd7, 16'd1, 16'd10}, 1'b1);
    wait_res(base + 2, "degen_count");
    chk("degen_mask0", res_mask[base], 4'b0000);
    chk("degen_mask1", res_mask[base+1], 4'b0000);
    chk("degen_pulses", deg_cnt - dbase, 1);

    // Full-range coordinates.
    base = res_mask.size();
    send_tri(0, 0, 65535, 0, 0, 65535);
    beat({16'd65535, 16'd0, 16'd1, 16'd65535}, {16'd1, 16'd65535, 16'd1, 16'd65535}, 1'b1);
    wait_res(base + 1, "big_count");
    chk("big_mask", res_mask[base], 4'b0110);

    // Six beats with a 5-cycle output stall after the 2nd result.
    base = res_mask.size();
    send_tri(0, 0, 10, 0, 0, 10);
    fork
      begin
        for (int k = 0; k < 6; k++) beat(by_mask(mseq[k*NL +: NL]), by_mask(mseq[k*NL +: NL]), k == 5);
      end
      begin
        int n;
        n = 0;
        while (res_mask.size() < base + 2 && n < 200) begin @(posedge clk_in); n++; end
        #1 cov_ready_in = 1'b0;
        mhold = cov_mask_out;
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("stall_pt_ready", pt_ready_out, 0);
        chk("stall_valid", cov_valid_out, 1);
        chk("stall_hold", cov_mask_out, mhold);
        @(posedge clk_in); #1 cov_ready_in = 1'b1;
      end
    join
    wait_res(base + 6, "bp_count");
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_mask%0d", k), res_mask[base+k], mseq[k*NL +: NL]);
      chk($sformatf("bp_last%0d", k), res_last[base+k], k == 5);
    end

    // Reset with two beats in flight.
    repeat (3) @(posedge clk_in); #1;
    base = res_mask.size();
    send_tri(0, 0, 10, 0, 0, 10);
    beat(by_mask(4'h3), by_mask(4'h3), 1'b0);
    beat(by_mask(4'hC), by_mask(4'hC), 1'b0);
    @(posedge clk_in); #1;
    chk("pre_rst_valid", cov_valid_out, 1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("inrst_valid", cov_valid_out, 0);
    chk("inrst_busy", busy_out, 0);
    chk("inrst_pt_ready", pt_ready_out, 0);
    chk("inrst_tri_ready", tri_ready_out, 0);
    #10 rst_n_in = 1'b1;
    #1;
    chk("rel_tri_ready_pre", tri_ready_out, 0);
    @(posedge clk_in); #1;
    chk("rel_tri_ready", tri_ready_out, 1);
    chk("rel_busy", busy_out, 0);
    repeat (6) @(posedge clk_in); #1;
    chk("rst_discard", res_mask.size(), base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
